// File: rtl/mod_counter.sv
// Up/down modulo counter (terminal count max_value) with wrap or saturate, clear/load, and a registered overflow pulse.
// Optional registered compare-match output is built when COUNTER_CMP_EN is defined.
module mod_counter #(
  parameter int unsigned           bitwidth  = 8,
  parameter logic [bitwidth-1:0]   max_value = '1,
  parameter bit                    saturate  = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                up,
  input  logic                clear,
  input  logic                load,
  input  logic [bitwidth-1:0] load_value,
  input  logic [bitwidth-1:0] cmp_value,
  output logic [bitwidth-1:0] counter_out,
  output logic                overflow,
  output logic                cmp_match
);

  localparam logic [bitwidth-1:0] max_c = max_value;

  logic [bitwidth-1:0] count_q;
  logic [bitwidth-1:0] count_d;
  logic                ovf_q;
  logic                ovf_d;
  logic                at_max;
  logic                at_zero;

  // Limits are judged against max_value, so counts above it can never arise.
  assign at_max  = (count_q >= max_c);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_value > max_c) ? max_c : load_value;
    end else if (enable) begin
      if (up) begin
        if (at_max) begin
          ovf_d   = 1'b1;
          count_d = saturate ? max_c : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          ovf_d   = 1'b1;
          count_d = saturate ? '0 : max_c;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter_out = count_q;
  assign overflow    = ovf_q;

`ifdef COUNTER_CMP_EN
  logic match_q;

  // Compare against the next count so the flag lines up with counter_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= (count_d == cmp_value);
    end
  end

  assign cmp_match = match_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^cmp_value;
  assign cmp_match  = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: wrapping and saturating instances (width 4, terminal 9) driven in parallel against an arithmetic model.
module tb_mod_counter;

  localparam int MAXV = 9;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       up;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] cmp_value;
  logic [3:0] cnt_w;
  logic       ovf_w;
  logic       match_w;
  logic [3:0] cnt_s;
  logic       ovf_s;
  logic       match_s;

  int checks;
  int failures;

  int m_w;
  int m_s;
  bit mo_w;
  bit mo_s;
  bit mm_w;
  bit mm_s;

  mod_counter #(.bitwidth(4), .max_value(4'd9), .saturate(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(load_value), .cmp_value(cmp_value),
    .counter_out(cnt_w), .overflow(ovf_w), .cmp_match(match_w)
  );

  mod_counter #(.bitwidth(4), .max_value(4'd9), .saturate(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(load_value), .cmp_value(cmp_value),
    .counter_out(cnt_s), .overflow(ovf_s), .cmp_match(match_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_w = 0; m_s = 0; mo_w = 0; mo_s = 0; mm_w = 0; mm_s = 0;
  endtask

  // Plain arithmetic view of the counter: modulus MAXV+1 for wrap, clamped range for saturate.
  task automatic model_step();
    int nw, ns;
    bit ow, os;
    nw = m_w; ns = m_s; ow = 0; os = 0;
    if (clear) begin
      nw = 0; ns = 0;
    end else if (load) begin
      nw = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
      ns = nw;
    end else if (enable) begin
      if (up) begin
        ow = (m_w == MAXV);
        os = (m_s == MAXV);
        nw = (m_w + 1) % (MAXV + 1);
        ns = (m_s + 1 > MAXV) ? MAXV : m_s + 1;
      end else begin
        ow = (m_w == 0);
        os = (m_s == 0);
        nw = (m_w + MAXV) % (MAXV + 1);
        ns = (m_s - 1 < 0) ? 0 : m_s - 1;
      end
    end
    m_w = nw; m_s = ns; mo_w = ow; mo_s = os;
`ifdef COUNTER_CMP_EN
    mm_w = (nw == int'(cmp_value));
    mm_s = (ns == int'(cmp_value));
`else
    mm_w = 0;
    mm_s = 0;
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit c, input bit l, input bit e, input bit u, input logic [3:0] lv);
    clear = c; load = l; enable = e; up = u; load_value = lv;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(0, 0, 0, 1, 4'd0);
    cmp_value = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cnt_w !== 4'd0 || ovf_w !== 1'b0 || match_w !== 1'b0 ||
        cnt_s !== 4'd0 || ovf_s !== 1'b0 || match_s !== 1'b0) begin
      failures++;
      $display("FAIL reset cnt_w=%0d ovf_w=%0b match_w=%0b cnt_s=%0d ovf_s=%0b match_s=%0b expected all 0",
               cnt_w, ovf_w, match_w, cnt_s, ovf_s, match_s);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_wrap_up();
    set_in(0, 0, 1, 1, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      checks++;
      if (cnt_w !== 4'(k % 10) || ovf_w !== (k == 10)) begin
        failures++;
        $display("FAIL wrap_up[%0d] counter_out=%0d overflow=%0b expected %0d/%0b",
                 k, cnt_w, ovf_w, k % 10, (k == 10));
      end
    end
    set_in(0, 0, 0, 1, 4'd0);
  endtask

  task automatic test_saturate_down();
    int exp_c[4];
    bit exp_o[4];
    exp_c = '{1, 0, 0, 0};
    exp_o = '{0, 0, 1, 1};
    set_in(0, 1, 0, 1, 4'd2);
    cycle();
    checks++;
    if (cnt_s !== 4'd2 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_load counter_out=%0d overflow=%0b expected 2/0", cnt_s, ovf_s);
    end
    set_in(0, 0, 1, 0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (cnt_s !== 4'(exp_c[k]) || ovf_s !== exp_o[k]) begin
        failures++;
        $display("FAIL sat_down[%0d] counter_out=%0d overflow=%0b expected %0d/%0b",
                 k, cnt_s, ovf_s, exp_c[k], exp_o[k]);
      end
    end
    set_in(0, 0, 0, 1, 4'd0);
  endtask

  task automatic test_load_clamp_priority();
    set_in(0, 1, 0, 1, 4'd14);
    cycle();
    checks++;
    if (cnt_w !== 4'd9 || cnt_s !== 4'd9 || ovf_w !== 1'b0) begin
      failures++;
      $display("FAIL load_clamp cnt_w=%0d cnt_s=%0d ovf=%0b expected 9/9/0", cnt_w, cnt_s, ovf_w);
    end
    set_in(1, 1, 1, 1, 4'd5);
    cycle();
    checks++;
    if (cnt_w !== 4'd0 || ovf_w !== 1'b0 || cnt_s !== 4'd0 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL clear_prio cnt_w=%0d ovf_w=%0b cnt_s=%0d ovf_s=%0b expected 0/0/0/0",
               cnt_w, ovf_w, cnt_s, ovf_s);
    end
    set_in(0, 1, 1, 1, 4'd3);
    cycle();
    checks++;
    if (cnt_w !== 4'd3 || ovf_w !== 1'b0) begin
      failures++;
      $display("FAIL load_prio counter_out=%0d overflow=%0b expected 3/0", cnt_w, ovf_w);
    end
    set_in(1, 0, 0, 1, 4'd0);
    cycle();
    set_in(0, 0, 0, 1, 4'd0);
  endtask

  task automatic test_down_wrap();
    set_in(0, 0, 1, 0, 4'd0);
    cycle();
    checks++;
    if (cnt_w !== 4'd9 || ovf_w !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap counter_out=%0d overflow=%0b expected 9/1", cnt_w, ovf_w);
    end
    set_in(0, 0, 0, 0, 4'd0);
    cycle();
    checks++;
    if (cnt_w !== 4'd9 || ovf_w !== 1'b0) begin
      failures++;
      $display("FAIL down_wrap_idle counter_out=%0d overflow=%0b expected 9/0", cnt_w, ovf_w);
    end
  endtask

  task automatic test_compare();
    bit exp_m;
    cmp_value = 4'd5;
    set_in(1, 0, 0, 1, 4'd0);
    cycle();
    set_in(0, 0, 1, 1, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      cycle();
`ifdef COUNTER_CMP_EN
      exp_m = (k == 5);
`else
      exp_m = 1'b0;
`endif
      checks++;
      if (match_w !== exp_m || cnt_w !== 4'(k)) begin
        failures++;
        $display("FAIL cmp_up[%0d] counter_out=%0d cmp_match=%0b expected %0d/%0b", k, cnt_w, match_w, k, exp_m);
      end
    end
    set_in(0, 0, 0, 1, 4'd0);
    repeat (2) begin
      cycle();
`ifdef COUNTER_CMP_EN
      exp_m = 1'b1;
`else
      exp_m = 1'b0;
`endif
      checks++;
      if (match_w !== exp_m || cnt_w !== 4'd5) begin
        failures++;
        $display("FAIL cmp_hold counter_out=%0d cmp_match=%0b expected 5/%0b", cnt_w, match_w, exp_m);
      end
    end
    set_in(0, 0, 1, 1, 4'd0);
    cycle();
    checks++;
    if (match_w !== 1'b0 || cnt_w !== 4'd6) begin
      failures++;
      $display("FAIL cmp_leave counter_out=%0d cmp_match=%0b expected 6/0", cnt_w, match_w);
    end
  endtask

  task automatic test_async_reset();
    cmp_value = 4'd7;
    set_in(1, 0, 0, 1, 4'd0);
    cycle();
    set_in(0, 0, 1, 1, 4'd0);
    repeat (7) cycle();
    checks++;
    if (cnt_w !== 4'd7) begin
      failures++;
      $display("FAIL pre_reset counter_out=%0d expected 7", cnt_w);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (cnt_w !== 4'd0 || ovf_w !== 1'b0 || match_w !== 1'b0 || cnt_s !== 4'd0 || match_s !== 1'b0) begin
      failures++;
      $display("FAIL async_reset cnt_w=%0d ovf_w=%0b match_w=%0b cnt_s=%0d match_s=%0b expected all 0",
               cnt_w, ovf_w, match_w, cnt_s, match_s);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle();
    checks++;
    if (cnt_w !== 4'd1 || cnt_s !== 4'd1 || ovf_w !== 1'b0) begin
      failures++;
      $display("FAIL post_reset cnt_w=%0d cnt_s=%0d ovf=%0b expected 1/1/0", cnt_w, cnt_s, ovf_w);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      clear      = ($urandom_range(0, 15) == 0);
      load       = ($urandom_range(0, 7) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      up         = ($urandom_range(0, 2) != 0);
      load_value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) cmp_value = 4'($urandom_range(0, 9));
      cycle();
      checks++;
      if (cnt_w !== 4'(m_w) || ovf_w !== mo_w || match_w !== mm_w ||
          cnt_s !== 4'(m_s) || ovf_s !== mo_s || match_s !== mm_s) begin
        failures++;
        if (bad < 10)
          $display("FAIL random[%0d] wrap=%0d/%0b/%0b sat=%0d/%0b/%0b expected wrap=%0d/%0b/%0b sat=%0d/%0b/%0b",
                   k, cnt_w, ovf_w, match_w, cnt_s, ovf_s, match_s, m_w, mo_w, mm_w, m_s, mo_s, mm_s);
        bad++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_wrap_up();
    test_saturate_down();
    test_load_clamp_priority();
    test_down_wrap();
    test_compare();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
